cordic_sincos_seq: RTL

//  Sequencer that sits directly upstream and downstream of cordic (circular rotation mode).

---
 rtl/cordic_sincos_seq_pkg.sv | 28 ++
 rtl/cordic_sincos_seq_if.sv | 23 ++
 rtl/cordic_sincos_seq_deg_reduce.sv | 72 +++++++
 rtl/cordic_sincos_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cordic_sincos_seq_pkg.sv
// Shared constants, mode encodings and FSM state type for the cordic sin/cos sequencer.
package cordic_sincos_seq_pkg;

  typedef enum logic {
    ModeRotation  = 1'b0,
    ModeVectoring = 1'b1
  } mode_op_e;

  typedef enum logic [1:0] {
    ModeLinear     = 2'b00,
    ModeCircular   = 2'b01,
    ModeHyperbolic = 2'b11
  } mode_coord_e;

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StIssue,
    StWait,
    StOut
  } state_e;

  // 0.60725293 in Q16.16 pre-compensates the cordic gain.
  localparam int signed KInvQ16    = 39797;
  // pi/180 in Q2.30.
  localparam int signed Deg2RadQ30 = 18740330;

endpackage

// File: rtl/cordic_sincos_seq_if.sv
// Request/response handshake bundle of the cordic sin/cos sequencer.
interface cordic_sincos_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_deg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sin_out;
  logic [WIDTH-1:0] cos_out;
  logic             err;

  modport master (
    output in_valid, in_deg, out_ready,
    input  in_ready, out_valid, sin_out, cos_out, err
  );

  modport slave (
    input  in_valid, in_deg, out_ready,
    output in_ready, out_valid, sin_out, cos_out, err
  );
endinterface

// File: rtl/cordic_sincos_seq_deg_reduce.sv
// Iterative degree reduction to [-180,180), fold to [-90,90] and conversion to Q16.16 radians.
module cordic_sincos_seq_deg_reduce
  import cordic_sincos_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      deg_in,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             neg_cos
);

  logic                    busy_q;
  logic signed [16:0]      d_q;
  logic [WIDTH-1:0]        z_q;
  logic                    neg_cos_q;
  logic                    in_range;
  logic signed [16:0]      d_fold;
  logic                    fold_neg;
  logic signed [47:0]      prod;
  logic signed [47:0]      z_full;
  logic [47-WIDTH:0]       unused_z_hi;

  assign in_range = (d_q < 17'sd180) && (d_q >= -17'sd180);
  assign done     = busy_q && in_range;

  always_comb begin
    d_fold   = d_q;
    fold_neg = 1'b0;
    if (d_q > 17'sd90) begin
      d_fold   = 17'sd180 - d_q;
      fold_neg = 1'b1;
    end else if (d_q < -17'sd90) begin
      d_fold   = -17'sd180 - d_q;
      fold_neg = 1'b1;
    end
  end

  // Round-to-nearest on the Q30 -> Q16 shift.
  assign prod        = $signed({{31{d_fold[16]}}, d_fold}) * 48'(Deg2RadQ30);
  assign z_full      = (prod + 48'sd8192) >>> 14;
  assign unused_z_hi = z_full[47:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      d_q       <= '0;
      z_q       <= '0;
      neg_cos_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      d_q    <= {deg_in[15], deg_in};
    end else if (busy_q) begin
      if (d_q >= 17'sd180) begin
        d_q <= d_q - 17'sd360;
      end else if (d_q < -17'sd180) begin
        d_q <= d_q + 17'sd360;
      end else begin
        busy_q    <= 1'b0;
        z_q       <= z_full[WIDTH-1:0];
        neg_cos_q <= fold_neg;
      end
    end
  end

  assign z       = z_q;
  assign neg_cos = neg_cos_q;

endmodule

// File: rtl/cordic_sincos_seq.sv
// Sequencer around a circular-rotation cordic producing sin/cos of an integer-degree angle.
// Optional WAIT watchdog enabled by defining CORDIC_SINCOS_TIMEOUT_EN.
module cordic_sincos_seq
  import cordic_sincos_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  cordic_sincos_seq_if.slave        bus,
  output logic                      cordic_enable,
  output logic                      cordic_mode_op,
  output logic [1:0]                cordic_mode_coord,
  output logic [WIDTH-1:0]          cordic_x_in,
  output logic [WIDTH-1:0]          cordic_y_in,
  output logic [WIDTH-1:0]          cordic_z_in,
  input  logic [WIDTH-1:0]          cordic_x_out,
  input  logic [WIDTH-1:0]          cordic_y_out,
  input  logic                      cordic_valid
);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             enable_q;
  logic [WIDTH-1:0] sin_q;
  logic [WIDTH-1:0] cos_q;
  logic             red_start;
  logic             red_done;
  logic             neg_cos;
  logic             timeout;

  assign red_start = (state_q == StIdle) && bus.in_valid;

  cordic_sincos_seq_deg_reduce #(
    .WIDTH (WIDTH)
  ) u_deg_reduce (
    .clk     (clk),
    .rst     (rst),
    .start   (red_start),
    .deg_in  (bus.in_deg),
    .done    (red_done),
    .z       (cordic_z_in),
    .neg_cos (neg_cos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      enable_q    <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_q    <= StReduce;
            in_ready_q <= 1'b0;
          end
        end
        StReduce: begin
          if (red_done) begin
            state_q  <= StIssue;
            enable_q <= 1'b1;
          end
        end
        StIssue: begin
          enable_q <= 1'b0;
          state_q  <= StWait;
        end
        StWait: begin
          if (cordic_valid) begin
            sin_q       <= cordic_y_out;
            cos_q       <= neg_cos ? (~cordic_x_out + 1'b1) : cordic_x_out;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else if (timeout) begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CORDIC_SINCOS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
      // Sticky until the next accepted request.
      if (red_start) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout = (state_q == StWait) && !cordic_valid &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign bus.err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus.err            = 1'b0;
`endif

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.sin_out       = sin_q;
  assign bus.cos_out       = cos_q;
  assign cordic_enable     = enable_q;
  assign cordic_mode_op    = ModeRotation;
  assign cordic_mode_coord = ModeCircular;
  assign cordic_x_in       = WIDTH'(KInvQ16);
  assign cordic_y_in       = '0;

endmodule
